// File: rtl/run_ctrl_pkg.sv
// Shared types and default constants for the run controller.
// The hold and drain phase counters are PHASE_W bits wide (phase lengths are limited to 255).
package run_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST_HOLD,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam int DEF_N_CORES      = 1;
  localparam int DEF_CNT_W        = 16;
  localparam int DEF_RST_CYCLES   = 4;
  localparam int DEF_DRAIN_CYCLES = 5;
  localparam int DEF_MAX_CYCLES   = 200;
  localparam int PHASE_W          = 8;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all ones; clear has priority over enable.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] ONE = W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en && (q != '1)) begin
      q <= q + ONE;
    end
  end

endmodule

// File: rtl/run_controller.sv
// Sequences core reset, the run window with a cycle budget, and pipeline drain.
// state     | meaning
// IDLE      | cores in reset, waiting for start
// RST_HOLD  | cores held in reset for RST_CYCLES cycles
// RUN       | cores advancing, counting cycles, collecting halts
// DRAIN     | all cores halted, pipeline empties for DRAIN_CYCLES cycles
// DONE      | results frozen until the next start
module run_controller
  import run_ctrl_pkg::*;
#(
  parameter int N_CORES      = DEF_N_CORES,
  parameter int CNT_W        = DEF_CNT_W,
  parameter int RST_CYCLES   = DEF_RST_CYCLES,
  parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES,
  parameter int MAX_CYCLES   = DEF_MAX_CYCLES
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [CNT_W-1:0]   limit_i,
  input  logic [N_CORES-1:0] halt_req,
  output logic [N_CORES-1:0] core_rst,
  output logic               run_en,
  output logic [CNT_W-1:0]   cycle_cnt,
  output logic [N_CORES-1:0] halted_mask,
  output logic               done,
  output logic               timeout
);

  localparam logic [PHASE_W-1:0] HOLD_LAST  = PHASE_W'(RST_CYCLES - 1);
  localparam logic [PHASE_W-1:0] DRAIN_LAST = PHASE_W'(DRAIN_CYCLES - 1);

  state_t               state, state_d;
  logic [31:0]          lim, lim_d;
  logic [PHASE_W-1:0]   hold_q, drain_q;
  logic [N_CORES-1:0]   core_rst_d, mask_d;
  logic                 run_en_d, done_d, timeout_d;
  logic                 start_ok, all_halted, exhausted, cnt_en;

  assign start_ok   = start && ((state == S_IDLE) || (state == S_DONE));
  assign all_halted = &(halted_mask | halt_req);
  // A saturated counter can never reach a budget wider than itself, so saturation also ends the run.
  assign exhausted  = (32'(cycle_cnt) == (lim - 32'd1)) || (&cycle_cnt);
  assign cnt_en     = ((state == S_RUN) && !(exhausted && !all_halted)) || (state == S_DRAIN);

  sat_counter #(.W(CNT_W)) u_cycle (
    .clk(clk), .rst(reset), .clr(start_ok), .en(cnt_en), .q(cycle_cnt)
  );

  sat_counter #(.W(PHASE_W)) u_hold (
    .clk(clk), .rst(reset), .clr(state != S_RST_HOLD), .en(1'b1), .q(hold_q)
  );

  sat_counter #(.W(PHASE_W)) u_drain (
    .clk(clk), .rst(reset), .clr(state != S_DRAIN), .en(1'b1), .q(drain_q)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      lim         <= 32'(MAX_CYCLES);
      core_rst    <= '1;
      run_en      <= 1'b0;
      halted_mask <= '0;
      done        <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      state       <= state_d;
      lim         <= lim_d;
      core_rst    <= core_rst_d;
      run_en      <= run_en_d;
      halted_mask <= mask_d;
      done        <= done_d;
      timeout     <= timeout_d;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_d = S_RST_HOLD;
      S_RST_HOLD:     if (hold_q == HOLD_LAST) state_d = S_RUN;
      S_RUN: begin
        if (all_halted) state_d = (DRAIN_CYCLES == 0) ? S_DONE : S_DRAIN;
        else if (exhausted) state_d = S_DONE;
      end
      S_DRAIN:        if (drain_q == DRAIN_LAST) state_d = S_DONE;
      default:        state_d = S_IDLE;
    endcase
  end

  always_comb begin
    core_rst_d = ((state_d == S_IDLE) || (state_d == S_RST_HOLD)) ? '1 : '0;
    run_en_d   = (state_d == S_RUN) || (state_d == S_DRAIN);
    done_d     = (state_d == S_DONE);
    timeout_d  = timeout;
    mask_d     = halted_mask;
    lim_d      = lim;
    if (start_ok) begin
      timeout_d = 1'b0;
      mask_d    = '0;
      lim_d     = (limit_i == '0) ? 32'(MAX_CYCLES) : 32'(limit_i);
    end else begin
      if ((state == S_RUN) && exhausted && !all_halted) timeout_d = 1'b1;
      if ((state == S_RUN) || (state == S_DRAIN)) mask_d = halted_mask | halt_req;
    end
  end

endmodule

// File: tb/tb_run_controller.sv
// Self-checking bench: three controller configurations against a run-level reference model.
module tb_run_controller;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  // A: two cores, default timing
  logic        start_a;
  logic [15:0] limit_a, cnt_a;
  logic [1:0]  halt_a, core_rst_a, mask_a;
  logic        run_en_a, done_a, to_a;
  // B: 4-bit counter, budget 20
  logic       start_b, halt_b, core_rst_b, run_en_b, mask_b, done_b, to_b;
  logic [3:0] limit_b, cnt_b;
  // C: one core, no drain
  logic        start_c, halt_c, core_rst_c, run_en_c, mask_c, done_c, to_c;
  logic [15:0] limit_c, cnt_c;

  run_controller #(.N_CORES(2)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .limit_i(limit_a), .halt_req(halt_a),
    .core_rst(core_rst_a), .run_en(run_en_a), .cycle_cnt(cnt_a), .halted_mask(mask_a),
    .done(done_a), .timeout(to_a));

  run_controller #(.N_CORES(1), .CNT_W(4), .MAX_CYCLES(20)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .limit_i(limit_b), .halt_req(halt_b),
    .core_rst(core_rst_b), .run_en(run_en_b), .cycle_cnt(cnt_b), .halted_mask(mask_b),
    .done(done_b), .timeout(to_b));

  run_controller #(.N_CORES(1), .DRAIN_CYCLES(0)) dut_c (
    .clk(clk), .reset(reset), .start(start_c), .limit_i(limit_c), .halt_req(halt_c),
    .core_rst(core_rst_c), .run_en(run_en_c), .cycle_cnt(cnt_c), .halted_mask(mask_c),
    .done(done_c), .timeout(to_c));

  // Reference: halt times h are RUN cycle indices (-1 = never); times counted in edges from the start edge.
  function automatic void model_a(input int lim, input int h0, input int h1, input int drain,
                                  output int done_at, output int cnt, output logic [1:0] mask,
                                  output logic to);
    int budget, last;
    budget = (lim == 0) ? 200 : lim;
    mask = 2'b00;
    if (h0 >= 0 && h1 >= 0 && h0 <= budget - 1 && h1 <= budget - 1) begin
      last = (h0 > h1) ? h0 : h1;
      to = 1'b0; mask = 2'b11;
      cnt = last + 1 + drain;
      done_at = 4 + last + 1 + drain;
    end else begin
      to = 1'b1;
      cnt = budget - 1;
      done_at = 4 + budget;
      mask[0] = (h0 >= 0 && h0 <= budget - 1);
      mask[1] = (h1 >= 0 && h1 <= budget - 1);
    end
  endfunction

  task automatic drive_a(input logic [15:0] lim, input int h0, input int h1, input bit noise,
                         output int done_at, output int run_at, output int rlow_at,
                         output logic [19:0] snap, output logic [15:0] cnt, output logic [1:0] mask,
                         output logic to, output logic dn, output logic ren);
    @(negedge clk);
    start_a = 1'b1; limit_a = lim; halt_a = 2'b00;
    @(posedge clk);
    done_at = -1; run_at = -1; rlow_at = -1; snap = '1;
    for (int e = 1; e <= 300; e++) begin
      @(negedge clk);
      if (e == 1) snap = {done_a, to_a, mask_a, cnt_a};
      if (run_at < 0 && run_en_a) run_at = e - 1;
      if (rlow_at < 0 && core_rst_a == 2'b00) rlow_at = e - 1;
      if (done_a) begin
        done_at = e - 1;
        break;
      end
      start_a = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      limit_a = 16'($urandom);
      halt_a[0] = (e - 5 == h0);
      halt_a[1] = (e - 5 == h1);
      if (noise && e < 5) halt_a = 2'($urandom);
    end
    start_a = 1'b0;
    repeat (3) begin
      halt_a = 2'($urandom);
      @(negedge clk);
    end
    halt_a = 2'b00;
    cnt = cnt_a; mask = mask_a; to = to_a; dn = done_a; ren = run_en_a;
  endtask

  task automatic drive_c(input logic [15:0] lim, input int h,
                         output int done_at, output logic [15:0] cnt, output logic to);
    @(negedge clk);
    start_c = 1'b1; limit_c = lim; halt_c = 1'b0;
    @(posedge clk);
    done_at = -1;
    for (int e = 1; e <= 300; e++) begin
      @(negedge clk);
      if (done_c) begin
        done_at = e - 1;
        break;
      end
      start_c = 1'b0;
      halt_c = (e - 5 == h);
    end
    start_c = 1'b0; halt_c = 1'b0;
    cnt = cnt_c; to = to_c;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    start_a = 0; limit_a = 0; halt_a = 0;
    start_b = 0; limit_b = 0; halt_b = 0;
    start_c = 0; limit_c = 0; halt_c = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({core_rst_a, run_en_a, cnt_a, mask_a, done_a, to_a} !== {2'b11, 1'b0, 16'd0, 2'b00, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_a: got rst=%b en=%b cnt=%0d mask=%b done=%b to=%b", core_rst_a, run_en_a, cnt_a, mask_a, done_a, to_a);
    end
    checks++;
    if ({core_rst_b, run_en_b, cnt_b, done_b, core_rst_c, run_en_c, cnt_c, done_c} !== {1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 16'd0, 1'b0}) begin
      failures++;
      $display("FAIL reset_bc: got b rst=%b en=%b cnt=%0d done=%b c rst=%b en=%b cnt=%0d done=%b expected 1 0 0 0 1 0 0 0",
               core_rst_b, run_en_b, cnt_b, done_b, core_rst_c, run_en_c, cnt_c, done_c);
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (run_en_a !== 1'b0 || core_rst_a !== 2'b11) begin
      failures++;
      $display("FAIL idle_wait: got en=%b rst=%b expected 0 11", run_en_a, core_rst_a);
    end
  endtask

  task automatic test_rst_hold;
    int done_at, run_at, rlow_at;
    logic [19:0] snap; logic [15:0] cnt; logic [1:0] mask; logic to, dn, ren;
    drive_a(16'd40, -1, -1, 1'b0, done_at, run_at, rlow_at, snap, cnt, mask, to, dn, ren);
    checks++;
    if (run_at !== 4 || rlow_at !== 4) begin
      failures++;
      $display("FAIL rst_hold: got run_en at edge %0d core_rst low at edge %0d expected 4 4", run_at, rlow_at);
    end
    checks++;
    if (done_at !== 44 || cnt !== 16'd39 || to !== 1'b1) begin
      failures++;
      $display("FAIL limit40: got done_at=%0d cnt=%0d to=%b expected 44 39 1", done_at, cnt, to);
    end
  endtask

  task automatic test_default_budget;
    int done_at; logic [15:0] cnt; logic to;
    drive_c(16'd0, -1, done_at, cnt, to);
    checks++;
    if (cnt !== 16'd199 || to !== 1'b1 || done_c !== 1'b1 || run_en_c !== 1'b0) begin
      failures++;
      $display("FAIL default_budget: got cnt=%0d to=%b done=%b en=%b expected 199 1 1 0", cnt, to, done_c, run_en_c);
    end
    checks++;
    if (done_at !== 204) begin
      failures++;
      $display("FAIL default_budget_time: got %0d expected 204", done_at);
    end
    drive_c(16'd50, 7, done_at, cnt, to);
    checks++;
    if (done_at !== 12 || cnt !== 16'd8 || to !== 1'b0 || mask_c !== 1'b1) begin
      failures++;
      $display("FAIL no_drain: got done_at=%0d cnt=%0d to=%b mask=%b expected 12 8 0 1", done_at, cnt, to, mask_c);
    end
  endtask

  task automatic test_two_core_drain;
    int done_at, run_at, rlow_at;
    logic [19:0] snap; logic [15:0] cnt; logic [1:0] mask; logic to, dn, ren;
    drive_a(16'd0, 10, 20, 1'b0, done_at, run_at, rlow_at, snap, cnt, mask, to, dn, ren);
    checks++;
    if (mask !== 2'b11 || to !== 1'b0 || cnt !== 16'd26 || dn !== 1'b1) begin
      failures++;
      $display("FAIL two_core_drain: got mask=%b to=%b cnt=%0d done=%b expected 11 0 26 1", mask, to, cnt, dn);
    end
    checks++;
    if (snap !== 20'd0) begin
      failures++;
      $display("FAIL restart_clear: got %h expected 0", snap);
    end
    drive_a(16'd30, 5, 29, 1'b0, done_at, run_at, rlow_at, snap, cnt, mask, to, dn, ren);
    checks++;
    if (to !== 1'b0 || cnt !== 16'd35 || mask !== 2'b11 || done_at !== 39) begin
      failures++;
      $display("FAIL halt_wins: got to=%b cnt=%0d mask=%b done_at=%0d expected 0 35 11 39", to, cnt, mask, done_at);
    end
  endtask

  task automatic test_reset_in_drain;
    int done_at, run_at, rlow_at;
    logic [19:0] snap; logic [15:0] cnt; logic [1:0] mask; logic to, dn, ren;
    @(negedge clk);
    start_a = 1'b1; limit_a = 16'd0;
    @(posedge clk);
    @(negedge clk);
    start_a = 1'b0;
    repeat (6) @(negedge clk);
    halt_a = 2'b11;
    @(negedge clk);
    halt_a = 2'b00;
    @(negedge clk);
    checks++;
    if (run_en_a !== 1'b1 || mask_a !== 2'b11 || done_a !== 1'b0) begin
      failures++;
      $display("FAIL drain_entry: got en=%b mask=%b done=%b expected 1 11 0", run_en_a, mask_a, done_a);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({core_rst_a, run_en_a, cnt_a, mask_a, done_a, to_a} !== {2'b11, 1'b0, 16'd0, 2'b00, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL async_abort: got rst=%b en=%b cnt=%0d mask=%b done=%b to=%b", core_rst_a, run_en_a, cnt_a, mask_a, done_a, to_a);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (run_en_a !== 1'b0 || core_rst_a !== 2'b11 || done_a !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_idle: got en=%b rst=%b done=%b expected 0 11 0", run_en_a, core_rst_a, done_a);
    end
    drive_a(16'd12, -1, -1, 1'b0, done_at, run_at, rlow_at, snap, cnt, mask, to, dn, ren);
    checks++;
    if (run_at !== 4 || rlow_at !== 4 || cnt !== 16'd11 || to !== 1'b1) begin
      failures++;
      $display("FAIL replay: got run_at=%0d rlow_at=%0d cnt=%0d to=%b expected 4 4 11 1", run_at, rlow_at, cnt, to);
    end
  endtask

  task automatic test_saturate;
    logic [3:0] prev;
    int wraps, seen;
    @(negedge clk);
    start_b = 1'b1; limit_b = 4'd0;
    @(negedge clk);
    start_b = 1'b0;
    prev = 4'd0; wraps = 0; seen = 0;
    for (int e = 0; e < 100; e++) begin
      @(negedge clk);
      if (cnt_b < prev) wraps++;
      prev = cnt_b;
      if (done_b) begin
        seen = 1;
        break;
      end
    end
    checks++;
    if (seen !== 1 || cnt_b !== 4'd15 || to_b !== 1'b1 || wraps !== 0) begin
      failures++;
      $display("FAIL saturate: got done=%0d cnt=%0d to=%b wraps=%0d expected 1 15 1 0", seen, cnt_b, to_b, wraps);
    end
  endtask

  task automatic test_random;
    int done_at, run_at, rlow_at, e_done, e_cnt, lim, h0, h1;
    logic [19:0] snap; logic [15:0] cnt; logic [1:0] mask, e_mask; logic to, dn, ren, e_to;
    for (int i = 0; i < 20; i++) begin
      lim = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 60));
      h0  = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 70));
      h1  = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 70));
      model_a(lim, h0, h1, 5, e_done, e_cnt, e_mask, e_to);
      drive_a(16'(lim), h0, h1, 1'b1, done_at, run_at, rlow_at, snap, cnt, mask, to, dn, ren);
      checks++;
      if (done_at !== e_done || cnt !== 16'(e_cnt) || mask !== e_mask || to !== e_to) begin
        failures++;
        $display("FAIL random[%0d] lim=%0d h=%0d,%0d: got done_at=%0d cnt=%0d mask=%b to=%b expected %0d %0d %b %b",
                 i, lim, h0, h1, done_at, cnt, mask, to, e_done, e_cnt, e_mask, e_to);
      end
      checks++;
      if (run_at !== 4 || snap !== 20'd0 || dn !== 1'b1 || ren !== 1'b0) begin
        failures++;
        $display("FAIL random_ctl[%0d]: got run_at=%0d snap=%h done=%b en=%b expected 4 0 1 0", i, run_at, snap, dn, ren);
      end
    end
  endtask

  initial begin
    test_reset;
    test_rst_hold;
    test_default_budget;
    test_two_core_drain;
    test_reset_in_drain;
    test_saturate;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/run_controller.md
RUN_CONTROLLER -- requirements
Module: run_controller

Interface
REQ-001 SHALL take parameter N_CORES, default 1: number of CPU cores controlled; legal range 1..8.
REQ-002 SHALL take parameter CNT_W, default 16: width of the cycle counter and limit.
REQ-003 SHALL take parameter RST_CYCLES, default 4: cycles core reset is held after start; legal range 1..255.
REQ-004 SHALL take parameter DRAIN_CYCLES, default 5: cycles run_en stays high after the last halt, to empty the pipeline; legal range 0..255.
REQ-005 SHALL take parameter MAX_CYCLES, default 200: default cycle budget, used when limit_i is 0.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-008 SHALL have port start, input, 1 bit: begin a run; sampled only in IDLE or DONE.
REQ-009 SHALL have port limit_i, input, CNT_W bits: run-time cycle budget; 0 selects MAX_CYCLES; sampled when start is accepted.
REQ-010 SHALL have port halt_req, input, N_CORES bits: per-core halt request pulse or level.
REQ-011 SHALL have port core_rst, output, N_CORES bits: per-core reset.
REQ-012 SHALL have port run_en, output, 1 bit: cores may advance.
REQ-013 SHALL have port cycle_cnt, output, CNT_W bits: number of RUN plus DRAIN cycles elapsed.
REQ-014 SHALL have port halted_mask, output, N_CORES bits: sticky record of which cores have halted.
REQ-015 SHALL have port done, output, 1 bit: the run has finished.
REQ-016 SHALL have port timeout, output, 1 bit: the run ended because the budget was exhausted.

Function
REQ-017 SHALL implement the states IDLE, RST_HOLD, RUN, DRAIN and DONE; all outputs are registered.
REQ-018 IDLE: core_rst is all ones and run_en is 0; on start=1, load limit and go to RST_HOLD.
REQ-019 RST_HOLD: core_rst SHALL be all ones for exactly RST_CYCLES cycles, then the block goes to RUN.
REQ-020 RUN entry: core_rst drops to 0 and run_en rises to 1 on the same edge.
REQ-021 RUN: cycle_cnt increments once per cycle, saturating at 2^CNT_W-1; halted_mask <= halted_mask | halt_req.
REQ-022 RUN: when (halted_mask | halt_req) is all ones, go to DRAIN.
REQ-023 RUN: when cycle_cnt equals limit-1 and not all cores have halted, go to DONE with timeout=1.
REQ-024 RUN: if all-halted and budget exhaustion occur in the same cycle, halt wins: go to DRAIN with timeout=0.
REQ-025 DRAIN: run_en stays 1 and cycle_cnt keeps counting for DRAIN_CYCLES cycles, then the block goes to DONE; with DRAIN_CYCLES=0 it goes straight to DONE.
REQ-026 DONE: run_en=0 and done=1; core_rst stays 0; cycle_cnt, halted_mask and timeout are frozen.
REQ-027 start in DONE: clear cycle_cnt, halted_mask, done and timeout, and go to RST_HOLD.
REQ-028 start SHALL be ignored in RST_HOLD, RUN and DRAIN.
REQ-029 halt_req SHALL be ignored outside RUN and DRAIN; in DRAIN it is still ORed into halted_mask.

Reset
REQ-030 On reset=1, asynchronously: state=IDLE, core_rst all ones, run_en=0, cycle_cnt=0, halted_mask=0, done=0, timeout=0.
REQ-031 Reset asserted mid-run SHALL abort immediately, with no drain.
REQ-032 After reset is released, the block SHALL wait for a new start.

Structure
REQ-033 Package run_ctrl_pkg SHALL hold the state enum and default parameter constants.
REQ-034 The saturating counter SHALL be a sub-module sat_counter (width parameter, clear, enable); it is reused for the hold and drain counters.

Verification
REQ-035 Reset, then start at cycle 0 with RST_CYCLES=4 -> core_rst high for 4 cycles, then run_en=1 on the 5th edge.
REQ-036 N_CORES=1, limit_i=0, no halt -> done=1 and timeout=1 with cycle_cnt=199.
REQ-037 N_CORES=2; halt_req=01 at RUN cycle 10, halt_req=10 at cycle 20; DRAIN_CYCLES=5 -> halted_mask=11, timeout=0, done after cycle_cnt=26.
REQ-038 limit_i=30; all cores halt at cycle_cnt=29 -> DRAIN with timeout=0 (halt wins).
REQ-039 Assert reset during DRAIN -> all outputs at reset values immediately; a new start replays REQ-035.
REQ-040 CNT_W=4, limit_i=0 with MAX_CYCLES=20 -> cycle_cnt saturates at 15, with no wrap, and timeout still asserts.
